// File: rtl/seg_text_scroller_if.sv
// Bus between the menu/ROM side and the scroller.
// Purpose: bundle the message-control inputs, the character-ROM lookup and the
//          display outputs of seg_text_scroller so they travel as one port.
// Signals:
//   start     menu -> scroller  one-cycle restart pulse
//   msg_len   menu -> scroller  message length, latched on start
//   loop      menu -> scroller  1 = repeat forever, 0 = one-shot
//   hold      menu -> scroller  freeze step counter and display
//   char_addr scroller -> ROM   character index being looked up
//   char_seg  ROM -> scroller   segment pattern for char_addr (combinational)
//   digits    scroller -> disp  digit k at [k*SEG_W +: SEG_W], k=0 leftmost
//   busy      scroller -> menu  message in progress
//   done      scroller -> menu  one-cycle pulse when a one-shot message is gone
interface seg_text_scroller_if #(
    parameter int N_DIGITS = 4,
    parameter int SEG_W    = 7,
    parameter int LEN_W    = 5
);
    logic                      start;
    logic [LEN_W-1:0]          msg_len;
    logic                      loop;
    logic                      hold;
    logic [LEN_W-1:0]          char_addr;
    logic [SEG_W-1:0]          char_seg;
    logic [N_DIGITS*SEG_W-1:0] digits;
    logic                      busy;
    logic                      done;

    modport master (
        output start, msg_len, loop, hold, char_seg,
        input  char_addr, digits, busy, done
    );

    modport slave (
        input  start, msg_len, loop, hold, char_seg,
        output char_addr, digits, busy, done
    );
endinterface

// File: rtl/seg_text_scroller.sv
// Generic scrolling-text engine for a bank of 7-segment digits.
// Text enters at the rightmost digit and shifts left once per step period.
// Loop mode repeats the message with GAP blank steps between copies; one-shot
// mode flushes the text out with blanks and then pulses done.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous reset, active high
//   bus    seg_text_scroller_if.slave (control, ROM lookup, display outputs)
module seg_text_scroller #(
    parameter int N_DIGITS = 4,
    parameter int SEG_W    = 7,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int CLK_HZ   = 27_000_000,
    parameter int STEP_HZ  = 2,
    parameter int GAP      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seg_text_scroller_if.slave  bus
);
    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int FL_W  = $clog2(N_DIGITS + 1);
    localparam int GAP_W = $clog2(GAP + 2);
    localparam int DW    = N_DIGITS * SEG_W;

    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_FLUSH} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_pos;
    logic [LEN_W-1:0]   r_len;
    logic               r_loop;
    logic [GAP_W-1:0]   r_gap;
    logic [FL_W-1:0]    r_flush;
    logic [DW-1:0]      r_digits;
    logic               r_busy;
    logic               r_done;
    logic               r_done_pend;   // zero-length start: done follows one cycle later

    logic               w_tick;
    logic [LEN_W-1:0]   w_len;
    logic               w_in_msg;
    logic [SEG_W-1:0]   w_entry;
    logic [DW-1:0]      w_shift;

    assign w_tick   = (r_cnt == CNT_W'(DIV - 1)) && !bus.hold;
    assign w_len    = (bus.msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.msg_len;
    assign w_in_msg = (r_pos < r_len);
    // Only a SCROLL step inside the message pulls a ROM pattern; gap and flush shift blanks.
    assign w_entry  = (r_state == S_SCROLL && w_in_msg) ? bus.char_seg : '0;
    // Digit 0 sits in the low bits, so moving everything left is a right shift of the vector.
    assign w_shift  = {w_entry, r_digits[DW-1:SEG_W]};

    assign bus.char_addr = w_in_msg ? r_pos : '0;
    assign bus.digits    = r_digits;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pos       <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_gap       <= '0;
            r_flush     <= '0;
            r_digits    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
            if (bus.start) begin
                // Restart wins over a same-cycle tick and cancels any pending done.
                r_cnt    <= '0;
                r_pos    <= '0;
                r_gap    <= '0;
                r_flush  <= '0;
                r_digits <= '0;
                r_len    <= w_len;
                r_loop   <= bus.loop;
                if (w_len == '0) begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done_pend <= 1'b1;
                end else begin
                    r_state <= S_SCROLL;
                    r_busy  <= 1'b1;
                end
            end else begin
                if (!bus.hold)
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (r_done_pend)
                    r_done <= 1'b1;
                case (r_state)
                    S_SCROLL: begin
                        if (w_tick) begin
                            r_digits <= w_shift;
                            if (w_in_msg) begin
                                r_pos <= r_pos + 1'b1;
                                if (r_pos + LEN_W'(1) == r_len) begin
                                    if (!r_loop) begin
                                        r_state <= S_FLUSH;
                                        r_flush <= '0;
                                    end else if (GAP == 0) begin
                                        r_pos <= '0;
                                    end
                                end
                            end else if (r_gap == GAP_W'(GAP - 1)) begin
                                // pos == len marks the blank gap between loop copies.
                                r_gap <= '0;
                                r_pos <= '0;
                            end else begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (w_tick) begin
                            r_digits <= w_shift;
                            if (r_flush == FL_W'(N_DIGITS - 1)) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_flush <= '0;
                            end else begin
                                r_flush <= r_flush + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
